// File: rtl/fifo_pkt_writer_pkg.sv
// Shared types and constants for the packet writer: FSM encoding, header layout, sizing and the
// latched header/descriptor record.
package fifo_pkt_writer_pkg;

    localparam int unsigned DataWidth   = 16;
    localparam int unsigned NumPriority = 8;
    localparam int unsigned SramDepth   = 1024;
    localparam int unsigned MaxPktWords = 64;
    localparam int unsigned Aw          = $clog2(SramDepth);
    localparam int unsigned PrioW       = $clog2(NumPriority);
    localparam int unsigned LenW        = 8;

    // Header word field offsets
    localparam int unsigned PrioLsb = 0;
    localparam int unsigned LenLsb  = 8;

    typedef enum logic [1:0] {
        StIdle,
        StData,
        StDrop,
        StDesc
    } pw_state_e;

    typedef struct packed {
        logic [Aw-1:0]    addr;
        logic [LenW-1:0]  len;
        logic [PrioW-1:0] prio;
    } pkt_hdr_t;

endpackage

// File: rtl/fifo_pkt_writer_if.sv
// Bundles the fifo head, SRAM write port, descriptor handshake and release port of the writer.
interface fifo_pkt_writer_if;
    import fifo_pkt_writer_pkg::*;

    logic                 fifo_ready;
    logic                 fifo_sop;
    logic                 fifo_eop;
    logic                 fifo_vld;
    logic [DataWidth-1:0] fifo_data;
    logic                 next_data;

    logic                 sram_wr_en;
    logic [Aw-1:0]        sram_wr_addr;
    logic [DataWidth-1:0] sram_wr_data;

    logic                 desc_vld;
    logic                 desc_ready;
    logic [Aw-1:0]        desc_addr;
    logic [LenW-1:0]      desc_len;
    logic [PrioW-1:0]     desc_prio;
    logic                 desc_len_err;

    logic                 rel_vld;
    logic [LenW-1:0]      rel_len;

    modport master (
        input  fifo_ready, fifo_sop, fifo_eop, fifo_vld, fifo_data, desc_ready, rel_vld, rel_len,
        output next_data, sram_wr_en, sram_wr_addr, sram_wr_data,
        output desc_vld, desc_addr, desc_len, desc_prio, desc_len_err
    );

    modport slave (
        output fifo_ready, fifo_sop, fifo_eop, fifo_vld, fifo_data, desc_ready, rel_vld, rel_len,
        input  next_data, sram_wr_en, sram_wr_addr, sram_wr_data,
        input  desc_vld, desc_addr, desc_len, desc_prio, desc_len_err
    );

endinterface

// File: rtl/fifo_pkt_writer_pkt_space_ctr.sv
// Tracks unreserved SRAM words: reserve, refund and release combine in one cycle, clamped to the
// ring size; ovf_o flags a clamp.
module fifo_pkt_writer_pkt_space_ctr
    import fifo_pkt_writer_pkg::*;
(
    input  logic            clk_i,
    input  logic            rst_ni,
    input  logic            res_en_i,
    input  logic [LenW-1:0] res_len_i,
    input  logic            ref_en_i,
    input  logic [LenW-1:0] ref_len_i,
    input  logic            rel_vld_i,
    input  logic [LenW-1:0] rel_len_i,
    output logic [Aw:0]     free_words_o,
    output logic            ovf_o
);

    // One spare bit so free + refund + release cannot wrap before the clamp
    localparam int unsigned SumW = Aw + 2;
    localparam logic [SumW-1:0] FullSum = SumW'(SramDepth);
    localparam logic [Aw:0] FullWords = (Aw + 1)'(SramDepth);

    logic [Aw:0]     free_q, free_d;
    logic [SumW-1:0] sum;

    always_comb begin
        sum = SumW'(free_q);
        if (res_en_i) sum = sum - SumW'(res_len_i);
        if (ref_en_i) sum = sum + SumW'(ref_len_i);
        if (rel_vld_i) sum = sum + SumW'(rel_len_i);
        ovf_o  = (sum > FullSum);
        free_d = ovf_o ? FullWords : sum[Aw:0];
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            free_q <= FullWords;
        end else begin
            free_q <= free_d;
        end
    end

    assign free_words_o = free_q;

endmodule

// File: rtl/fifo_pkt_writer.sv
// Drains packets from a first-word-fall-through fifo into the SRAM ring with length-based admission,
// then presents one descriptor per packet to the scheduler.
module fifo_pkt_writer
    import fifo_pkt_writer_pkg::*;
(
    input  logic               clk_i,
    input  logic               rst_ni,
    fifo_pkt_writer_if.master  bus,
    output logic [Aw:0]        free_words_o,
    output logic [15:0]        drop_cnt_o,
    output logic               err_pulse_o
);

    pw_state_e            state_q, state_d;
    pkt_hdr_t             hdr_q, hdr_d;
    logic [Aw-1:0]        wptr_q, wptr_d;
    logic [LenW-1:0]      cnt_q, cnt_d;
    logic                 len_err_q, len_err_d;
    logic [15:0]          drop_cnt_q, drop_cnt_d;
    logic                 wr_en_q, wr_en_d;
    logic [Aw-1:0]        wr_addr_q, wr_addr_d;
    logic [DataWidth-1:0] wr_data_q, wr_data_d;
    logic                 err_q;

    logic                 pop, res_en, ref_en, orphan, space_ovf, admit;
    logic [LenW-1:0]      hdr_len, ref_len;
    logic [PrioW-1:0]     hdr_prio;
    logic [Aw:0]          free_words;

    assign hdr_len  = bus.fifo_data[LenLsb +: LenW];
    assign hdr_prio = bus.fifo_data[PrioLsb +: PrioW];
    assign admit    = (hdr_len != '0) && (hdr_len <= LenW'(MaxPktWords)) &&
                      ((Aw + 1)'(hdr_len) <= free_words);
    // cnt never exceeds the declared length, so the unused reservation is non-negative
    assign ref_len  = hdr_q.len - cnt_q;

    always_comb begin
        state_d    = state_q;
        hdr_d      = hdr_q;
        wptr_d     = wptr_q;
        cnt_d      = cnt_q;
        len_err_d  = len_err_q;
        drop_cnt_d = drop_cnt_q;
        wr_en_d    = 1'b0;
        wr_addr_d  = wr_addr_q;
        wr_data_d  = wr_data_q;
        pop        = 1'b0;
        res_en     = 1'b0;
        ref_en     = 1'b0;
        orphan     = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (bus.fifo_ready) begin
                    pop = 1'b1;
                    if (bus.fifo_sop) begin
                        hdr_d.addr = wptr_q;
                        hdr_d.len  = hdr_len;
                        hdr_d.prio = hdr_prio;
                        cnt_d      = '0;
                        len_err_d  = 1'b0;
                        if (admit) begin
                            res_en  = 1'b1;
                            state_d = StData;
                        end else begin
                            state_d = StDrop;
                            if (drop_cnt_q != 16'hFFFF) drop_cnt_d = drop_cnt_q + 16'd1;
                        end
                    end else begin
                        orphan = 1'b1;
                    end
                end
            end
            StData: begin
                if (bus.fifo_ready) begin
                    if (bus.fifo_sop) begin
                        // Next header is left at the head for IDLE to handle
                        len_err_d = 1'b1;
                        ref_en    = 1'b1;
                        state_d   = StDesc;
                    end else begin
                        pop = 1'b1;
                        if (bus.fifo_eop) begin
                            ref_en  = 1'b1;
                            state_d = StDesc;
                        end else if (bus.fifo_vld) begin
                            if (cnt_q < hdr_q.len) begin
                                wr_en_d   = 1'b1;
                                wr_addr_d = wptr_q;
                                wr_data_d = bus.fifo_data;
                                wptr_d    = wptr_q + 1'b1;
                                cnt_d     = cnt_q + 1'b1;
                            end else begin
                                len_err_d = 1'b1;
                            end
                        end
                    end
                end
            end
            StDrop: begin
                if (bus.fifo_ready) begin
                    if (bus.fifo_sop) begin
                        state_d = StIdle;
                    end else begin
                        pop = 1'b1;
                        if (bus.fifo_eop) state_d = StIdle;
                    end
                end
            end
            StDesc: begin
                if (bus.desc_ready) state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q    <= StIdle;
            hdr_q      <= '0;
            wptr_q     <= '0;
            cnt_q      <= '0;
            len_err_q  <= 1'b0;
            drop_cnt_q <= '0;
            wr_en_q    <= 1'b0;
            wr_addr_q  <= '0;
            wr_data_q  <= '0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            hdr_q      <= hdr_d;
            wptr_q     <= wptr_d;
            cnt_q      <= cnt_d;
            len_err_q  <= len_err_d;
            drop_cnt_q <= drop_cnt_d;
            wr_en_q    <= wr_en_d;
            wr_addr_q  <= wr_addr_d;
            wr_data_q  <= wr_data_d;
            err_q      <= orphan | space_ovf;
        end
    end

    fifo_pkt_writer_pkt_space_ctr u_pkt_space_ctr (
        .clk_i        (clk_i),
        .rst_ni       (rst_ni),
        .res_en_i     (res_en),
        .res_len_i    (hdr_len),
        .ref_en_i     (ref_en),
        .ref_len_i    (ref_len),
        .rel_vld_i    (bus.rel_vld),
        .rel_len_i    (bus.rel_len),
        .free_words_o (free_words),
        .ovf_o        (space_ovf)
    );

    assign bus.next_data    = pop;
    assign bus.sram_wr_en   = wr_en_q;
    assign bus.sram_wr_addr = wr_addr_q;
    assign bus.sram_wr_data = wr_data_q;
    assign bus.desc_vld     = (state_q == StDesc);
    assign bus.desc_addr    = bus.desc_vld ? hdr_q.addr : '0;
    assign bus.desc_len     = bus.desc_vld ? cnt_q : '0;
    assign bus.desc_prio    = bus.desc_vld ? hdr_q.prio : '0;
    assign bus.desc_len_err = bus.desc_vld & ((cnt_q != hdr_q.len) | len_err_q);
    assign free_words_o     = free_words;
    assign drop_cnt_o       = drop_cnt_q;
    assign err_pulse_o      = err_q;

endmodule
